// File: rtl/inner_product_stream.sv
// -----------------------------------------------------------------------------
// inner_product_stream
//
// Streaming dot product of two length-N vectors of DW-bit elements. Each input
// beat carries L lanes per operand, so one vector takes N/L beats. Lane
// products are summed per beat and accumulated into an OW-bit register.
// Arithmetic wraps modulo 2^OW. SIGNED selects unsigned (0) or
// two's-complement (1) operands. Framing is purely count-based.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous abort of the partially accumulated vector
//   in_valid   beat on inp1/inp2 is valid
//   in_ready   a beat is accepted this cycle when in_valid is also high
//   inp1       operand A lanes, lane i = inp1[(i+1)*DW-1 : i*DW]
//   inp2       operand B lanes, same packing as inp1
//   out_valid  outp holds a completed result
//   out_ready  downstream accepts outp
//   outp       dot-product result (OW bits)
// -----------------------------------------------------------------------------
module inner_product_stream #(
    parameter int N      = 8,
    parameter int L      = 4,
    parameter int DW     = 8,
    parameter int OW     = 19,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW*L-1:0] inp1,
    input  logic [DW*L-1:0] inp2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   outp
);

    localparam int NB = N / L;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = 2 * DW;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

    // One lane product, extended (zero or sign) or truncated to OW bits.
    function automatic logic [OW-1:0] lane_product(input logic [DW-1:0] a,
                                                    input logic [DW-1:0] b);
        logic signed [PW-1:0] sp;
        logic        [PW-1:0] up;
        logic        [OW-1:0] r;
        sp = PW'($signed(a)) * PW'($signed(b));
        up = PW'(a) * PW'(b);
        if (SIGNED != 0) begin
            r = OW'(sp);
        end else begin
            r = OW'(up);
        end
        return r;
    endfunction

    // Sum of all L lane products of one beat, modulo 2^OW.
    function automatic logic [OW-1:0] beat_sum(input logic [DW*L-1:0] v1,
                                                input logic [DW*L-1:0] v2);
        logic [OW-1:0] s;
        s = {OW{1'b0}};
        for (int i = 0; i < L; i++) begin
            s = s + lane_product(v1[i*DW +: DW], v2[i*DW +: DW]);
        end
        return s;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [OW-1:0] acc_r;
    logic [OW-1:0] outp_r;
    logic          out_valid_r;

    logic          in_ready_s;
    logic          accept_s;
    logic          last_s;
    logic [OW-1:0] beat_sum_s;
    logic [OW-1:0] total_s;

    // Handshake decode and running total including the current beat.
    always_comb begin
        in_ready_s = !rst && !flush && (!out_valid_r || out_ready);
        accept_s   = in_valid && in_ready_s;
        last_s     = (cnt_r == LAST_BEAT);
        beat_sum_s = beat_sum(inp1, inp2);
        // The first beat of a vector starts from zero, so stale acc is ignored.
        if (cnt_r == {CW{1'b0}}) begin
            total_s = beat_sum_s;
        end else begin
            total_s = acc_r + beat_sum_s;
        end
    end

    // Beat counter and partial-sum accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            acc_r <= {OW{1'b0}};
        end else if (flush) begin
            cnt_r <= {CW{1'b0}};
            acc_r <= {OW{1'b0}};
        end else if (accept_s) begin
            if (last_s) begin
                cnt_r <= {CW{1'b0}};
                acc_r <= acc_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
                acc_r <= total_s;
            end
        end else begin
            cnt_r <= cnt_r;
            acc_r <= acc_r;
        end
    end

    // Result register and output handshake; a new last beat overrides consumption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outp_r      <= {OW{1'b0}};
            out_valid_r <= 1'b0;
        end else if (accept_s && last_s) begin
            outp_r      <= total_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            outp_r      <= outp_r;
            out_valid_r <= 1'b0;
        end else begin
            outp_r      <= outp_r;
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign outp      = outp_r;

endmodule

// File: tb/tb_inner_product_stream.sv
module tb_inner_product_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] inp1 = 32'h0;
    logic [31:0] inp2 = 32'h0;

    logic        ir_u, ov_u, ir_s, ov_s, ir_w, ov_w;
    logic [18:0] op_u, op_s;
    logic [15:0] op_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Unsigned, default widths.
    inner_product_stream #(.N(8), .L(4), .DW(8), .OW(19), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_u),
        .inp1(inp1), .inp2(inp2), .out_valid(ov_u), .out_ready(out_ready), .outp(op_u));

    // Signed, same stimulus.
    inner_product_stream #(.N(8), .L(4), .DW(8), .OW(19), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_s),
        .inp1(inp1), .inp2(inp2), .out_valid(ov_s), .out_ready(out_ready), .outp(op_s));

    // Unsigned, narrow 16-bit accumulator (wraps).
    inner_product_stream #(.N(8), .L(4), .DW(8), .OW(16), .SIGNED(0)) u_w16 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_w),
        .inp1(inp1), .inp2(inp2), .out_valid(ov_w), .out_ready(out_ready), .outp(op_w));

    typedef struct {
        logic [31:0] a0, b0, a1, b1;
        logic [18:0] exp_u;
        logic [18:0] exp_s;
        logic [15:0] exp_w;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        inp1 = a;
        inp2 = b;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // a0/b0 = beat 1, a1/b1 = beat 2; lane 0 is the low byte.
        vecs[0] = '{32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101, 19'd8, 19'd8, 16'd8};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 19'd520200, 19'd8, 16'd61448};
        vecs[2] = '{32'h7F000380, 32'h0105FE80, 32'hFFFFFFFF, 32'h01010101, 19'd18293, 19'd16501, 16'd18293};
        vecs[3] = '{32'hFFFFFFFF, 32'h01010101, 32'hFFFFFFFF, 32'h01010101, 19'd2040, 19'h7FFF8, 16'd2040};
        vecs[4] = '{32'h04030201, 32'h08070605, 32'h00000010, 32'h00000010, 19'd326, 19'd326, 16'd326};
        vecs[5] = '{32'h000000FF, 32'h00000002, 32'h02000000, 32'h80000000, 19'd766, 19'h7FEFE, 16'd766};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {29'd0, ir_u, ir_s, ir_w}, 32'd0);
        chk("rst_out_valid", {29'd0, ov_u, ov_s, ov_w}, 32'd0);
        chk("rst_outp", op_u, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", ir_u, 32'd1);

        // Table-driven vectors with out_ready high.
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("v%0d_in_ready", i), ir_u, 32'd1);
            beat(vecs[i].a0, vecs[i].b0);
            chk($sformatf("v%0d_mid_valid", i), ov_u, 32'd0);
            beat(vecs[i].a1, vecs[i].b1);
            chk($sformatf("v%0d_out_valid", i), {30'd0, ov_u, ov_s}, 32'd3);
            chk($sformatf("v%0d_outp_u", i), op_u, vecs[i].exp_u);
            chk($sformatf("v%0d_outp_s", i), op_s, vecs[i].exp_s);
            chk($sformatf("v%0d_outp_w", i), op_w, vecs[i].exp_w);
            step();
            chk($sformatf("v%0d_valid_drop", i), {31'd0, ov_w}, {31'd0, ov_u});
            chk($sformatf("v%0d_valid_low", i), ov_u, 32'd0);
        end

        // Backpressure: result A held, next vector stalled.
        out_ready = 1'b0;
        beat(32'h01010101, 32'h01010101);
        beat(32'h01010101, 32'h01010101);
        in_valid = 1'b1;
        inp1 = 32'h02020202;
        inp2 = 32'h03030303;
        #1;
        chk("bp_in_ready_low", ir_u, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp_hold_valid%0d", k), ov_u, 32'd1);
            chk($sformatf("bp_hold_outp%0d", k), op_u, 32'd8);
            chk($sformatf("bp_hold_ready%0d", k), ir_u, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_rise", ir_u, 32'd1);
        step();
        chk("bp_consumed", ov_u, 32'd0);
        step();
        in_valid = 1'b0;
        chk("bp_next_valid", ov_u, 32'd1);
        chk("bp_next_outp", op_u, 32'd48);
        chk("bp_next_outp_s", op_s, 32'd48);
        step();

        // Flush while a result is pending leaves it intact.
        out_ready = 1'b0;
        beat(32'h01010101, 32'h01010101);
        beat(32'h01010101, 32'h01010101);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_pend_valid", ov_u, 32'd1);
        chk("flush_pend_outp", op_u, 32'd8);
        out_ready = 1'b1;
        step();
        chk("flush_pend_done", ov_u, 32'd0);

        // Flush mid-vector discards the partial sum.
        beat(32'h01010101, 32'h01010101);
        in_valid = 1'b1;
        inp1 = 32'h02020202;
        inp2 = 32'h03030303;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", ir_u, 32'd0);
        step();
        flush = 1'b0;
        step();
        chk("flush_mid_valid", ov_u, 32'd0);
        step();
        in_valid = 1'b0;
        chk("flush_valid", ov_u, 32'd1);
        chk("flush_outp", op_u, 32'd48);
        step();

        // Back-to-back: four vectors, results every second cycle.
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            inp1 = {4{8'((k + 1) / 2)}};
            inp2 = 32'h01010101;
            step();
            chk($sformatf("b2b_valid%0d", k), ov_u, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) begin
                chk($sformatf("b2b_outp%0d", k), op_u, 32'(8 * (k / 2)));
            end
        end

        // Reset mid-vector: one beat of the next vector accepted, then rst.
        inp1 = 32'h05050505;
        step();
        in_valid = 1'b0;
        chk("pre_rst_outp", op_u, 32'd32);
        rst = 1'b1;
        #2;
        chk("rst_mid_valid", ov_u, 32'd0);
        chk("rst_mid_outp", op_u, 32'd0);
        chk("rst_mid_ready", ir_u, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(32'h01010101, 32'h01010101);
        chk("post_rst_mid", ov_u, 32'd0);
        beat(32'h01010101, 32'h01010101);
        chk("post_rst_valid", ov_u, 32'd1);
        chk("post_rst_outp", op_u, 32'd8);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
